ov7670_frame_ctrl: RTL and testbench
====================================

Name: ov7670_frame_ctrl

Overview:
- Frame-level sequencer between the OV7670 capture block and a two-bank (ping-pong) frame buffer RAM.
- Gates the capture write stream so that only whole frames are written.
- Steers each frame into the back bank, then swaps banks at the frame end once the display reader releases the front bank.
- Supports continuous and single-snapshot modes, discards warm-up frames, and counts completed and dropped frames.

Parameters:
- PIX_PER_FRAME, 76800: expected pixel writes per frame (320x240).
- ADDR_W, 17: capture address width.
- SKIP_FRAMES, 2: whole frames discarded after each start. Used for AEC/AWB settling. 0 means no skip.

Ports:
- pclk  in  1: pixel clock. Sole clock of the block.
- rst_n  in  1: asynchronous, active-low reset.
- enable  in  1: master enable. Low aborts and returns the block to IDLE.
- cont_mode  in  1: 1 = continuous capture, 0 = single snapshot.
- snap_req  in  1: one-cycle pulse. Starts a snapshot. Honoured only in IDLE with enable=1.
- vsync  in  1: camera VSYNC, already synchronous to pclk. High = blanking.
- cap_addr  in  ADDR_W: pixel address from the capture block.
- cap_dout  in  16: RGB565 pixel from the capture block.
- cap_we  in  1: pixel write strobe from the capture block.
- rd_busy  in  1: display is mid-frame on the front bank. A swap is forbidden while high.
- fb_addr  out  ADDR_W+1: RAM address, {back_bank, cap_addr}.
- fb_din  out  16: RAM write data.
- fb_we  out  1: RAM write enable.
- front_bank  out  1: bank the display reads.
- frame_done  out  1: one-cycle pulse on each bank swap.
- busy  out  1: high whenever state is not IDLE.
- frame_cnt  out  8: completed frames. Wraps at 255->0.
- drop_cnt  out  8: frames dropped because the swap was blocked. Saturates at 255.
- pix_err  out  1: sticky pixel-count error (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All outputs 0; front_bank=0.
  - Counters cleared; vsync edge register cleared.
- Edge detection:
  - vs_d is vsync delayed by one cycle.
  - vs_rise = vsync & ~vs_d (frame end).
  - vs_fall = ~vsync & vs_d (frame start).
- back_bank = ~front_bank at all times.
- States:
  - IDLE: fb_we=0. If enable & (cont_mode | snap_req): load skip_cnt=SKIP_FRAMES and clear pix_err. Go to SKIP, or directly to ARM if SKIP_FRAMES=0.
  - SKIP: decrement skip_cnt on each vs_rise. At 0, go to ARM. No writes are forwarded.
  - ARM: wait for vs_fall, then go to CAPTURE and clear pix_cnt. An ARM entered mid-frame never captures a partial frame.
  - CAPTURE: forward writes. On vs_rise go to SWAP. A write coinciding with vs_rise is still forwarded.
  - SWAP, rd_busy=0: toggle front_bank, pulse frame_done, increment frame_cnt. Then go to ARM if enable & cont_mode, otherwise IDLE.
  - SWAP, rd_busy=1, cont_mode=1: on vs_fall, increment drop_cnt (saturating), clear pix_cnt and go to CAPTURE. The back bank is overwritten and no swap occurs.
  - SWAP, rd_busy=1, cont_mode=0: keep waiting for rd_busy=0. Never drop.
- Write forwarding (CAPTURE only):
  - fb_we, fb_addr and fb_din are registered, with 1 pclk latency from cap_we.
  - A write with cap_addr >= PIX_PER_FRAME is suppressed (fb_we=0).
  - fb_we=0 in every other state.
- enable low in any non-IDLE state: go to IDLE next cycle. fb_we=0 from that cycle onward. No swap and no frame_done; front_bank is unchanged.
- snap_req while busy: ignored.
- Mode change: cont_mode is sampled only at IDLE exit and at SWAP completion.

Optional Feature:
- Macro: FRAME_CTRL_PIXCHK_EN.
- Defined:
  - An 18-bit saturating pix_cnt counts forwarded writes in CAPTURE.
  - At SWAP entry, if pix_cnt != PIX_PER_FRAME, pix_err is set. It stays sticky until the next IDLE exit.
  - The errored frame is still swapped.
- Not defined: no counter is built and pix_err is tied to 0.

Test Plan:
- Reset with PIX_PER_FRAME=16, SKIP_FRAMES=1, enable=1, cont_mode=1 -> first vsync cycle skipped, second frame's 16 writes appear as fb_we with fb_addr[ADDR_W]=1 one cycle after cap_we. At vs_rise: front_bank 0->1, frame_done one pulse, frame_cnt=1.
- Snapshot: cont_mode=0, snap_req pulse, SKIP_FRAMES=0 -> exactly one frame written, one swap, then IDLE with busy=0. A further camera frame produces fb_we=0 throughout.
- rd_busy held high over frame end in continuous mode -> no swap, drop_cnt=1, next frame rewrites the same bank. Release rd_busy -> swap at the following vs_rise, frame_cnt increments.
- enable dropped mid-CAPTURE after 5 writes -> fb_we=0 the next cycle, state IDLE, front_bank unchanged, no frame_done.
- cap_addr=PIX_PER_FRAME with cap_we=1 -> no fb_we. With FRAME_CTRL_PIXCHK_EN and a 15-pixel frame -> pix_err=1 at swap, cleared at the next start.
- Enable asserted while vsync is low mid-frame -> no writes until the next vs_fall (ARM held), then a full frame is captured.

Source files
------------

// File: rtl/ov7670_frame_ctrl.sv
// Frame sequencer: gates OV7670 capture writes into a ping-pong frame buffer, whole frames only.
// Optional build macro FRAME_CTRL_PIXCHK_EN adds the per-frame pixel-count check driving pix_err.
module ov7670_frame_ctrl #(
    parameter int PIX_PER_FRAME = 76800,
    parameter int ADDR_W        = 17,
    parameter int SKIP_FRAMES   = 2
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cont_mode,
    input  logic              snap_req,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [15:0]       cap_dout,
    input  logic              cap_we,
    input  logic              rd_busy,
    output logic [ADDR_W:0]   fb_addr,
    output logic [15:0]       fb_din,
    output logic              fb_we,
    output logic              front_bank,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        drop_cnt,
    output logic              pix_err
);

    localparam int              SKW     = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(PIX_PER_FRAME);

    typedef enum logic [2:0] {IDLE, SKIP, ARM, CAPTURE, SWAP} state_t;

    state_t           state, state_nxt;
    logic             vs_d, vs_rise, vs_fall;
    logic [SKW-1:0]   skip_cnt;
    logic             cont_q;
    logic             start, do_swap, do_drop, fwd;
    logic             back_bank;

    assign vs_rise   = vsync & ~vs_d;
    assign vs_fall   = ~vsync & vs_d;
    assign back_bank = ~front_bank;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        do_swap   = 1'b0;
        do_drop   = 1'b0;
        fwd       = (state == CAPTURE) && enable && cap_we && ({1'b0, cap_addr} < PIX_LIM);
        unique case (state)
            IDLE: if (enable && (cont_mode || snap_req)) begin
                start     = 1'b1;
                state_nxt = (SKIP_FRAMES == 0) ? ARM : SKIP;
            end
            SKIP:    if (vs_rise && skip_cnt <= SKW'(1)) state_nxt = ARM;
            ARM:     if (vs_fall) state_nxt = CAPTURE;
            CAPTURE: if (vs_rise) state_nxt = SWAP;
            SWAP: if (!rd_busy) begin
                do_swap   = 1'b1;
                state_nxt = cont_mode ? ARM : IDLE;
            end else if (cont_q && vs_fall) begin
                // reader still holds the front bank: overwrite the back bank with the new frame
                do_drop   = 1'b1;
                state_nxt = CAPTURE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable && state != IDLE) begin
            state_nxt = IDLE;
            do_swap   = 1'b0;
            do_drop   = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vs_d       <= 1'b0;
            skip_cnt   <= '0;
            cont_q     <= 1'b0;
            front_bank <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_din     <= '0;
        end else begin
            state      <= state_nxt;
            vs_d       <= vsync;
            frame_done <= do_swap;
            fb_we      <= fwd;
            if (fwd) begin
                fb_addr <= {back_bank, cap_addr};
                fb_din  <= cap_dout;
            end
            if (start) begin
                skip_cnt <= SKW'(SKIP_FRAMES);
                cont_q   <= cont_mode;
            end else if (state == SKIP && vs_rise && skip_cnt != '0) begin
                skip_cnt <= skip_cnt - 1'b1;
            end
            if (do_swap) begin
                front_bank <= ~front_bank;
                frame_cnt  <= frame_cnt + 1'b1;
                cont_q     <= cont_mode;
            end
            if (do_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef FRAME_CTRL_PIXCHK_EN
    logic [17:0] pix_cnt, pix_cnt_nxt;

    // the write that coincides with vs_rise is included in the count checked at SWAP entry
    always_comb begin
        pix_cnt_nxt = pix_cnt;
        if (fwd && pix_cnt != '1) pix_cnt_nxt = pix_cnt + 1'b1;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            pix_err <= 1'b0;
        end else begin
            if (state_nxt == CAPTURE && state != CAPTURE) pix_cnt <= '0;
            else                                          pix_cnt <= pix_cnt_nxt;
            if (start) pix_err <= 1'b0;
            else if (state == CAPTURE && state_nxt == SWAP && pix_cnt_nxt != 18'(PIX_PER_FRAME))
                pix_err <= 1'b1;
        end
    end
`else
    assign pix_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Randomized bench for ov7670_frame_ctrl: frame-level reference model plus a write scoreboard.
module tb_ov7670_frame_ctrl;

    localparam int PIX  = 16;
    localparam int AW   = 8;
    localparam int SKIP = 1;
`ifdef FRAME_CTRL_PIXCHK_EN
    localparam bit PIXCHK = 1'b1;
`else
    localparam bit PIXCHK = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst_n, enable, cont_mode, snap_req, vsync, rd_busy, cap_we;
    logic [AW-1:0] cap_addr;
    logic [15:0]   cap_dout;
    logic [AW:0]   fb_addr;
    logic [15:0]   fb_din;
    logic          fb_we, front_bank, frame_done, busy, pix_err;
    logic [7:0]    frame_cnt, drop_cnt;

    int  n_chk = 0, n_err = 0, fd_seen = 0;
    bit  fd_prev = 1'b0;
    logic [AW+16:0] exp_q[$];
    logic [AW+16:0] exp_w;
    bit  m_front = 1'b0, m_pix_err = 1'b0;
    int  m_frames = 0, m_drops = 0;

    always #5 pclk = ~pclk;

    ov7670_frame_ctrl #(.PIX_PER_FRAME(PIX), .ADDR_W(AW), .SKIP_FRAMES(SKIP)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .cont_mode(cont_mode),
        .snap_req(snap_req), .vsync(vsync), .cap_addr(cap_addr), .cap_dout(cap_dout),
        .cap_we(cap_we), .rd_busy(rd_busy), .fb_addr(fb_addr), .fb_din(fb_din),
        .fb_we(fb_we), .front_bank(front_bank), .frame_done(frame_done), .busy(busy),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .pix_err(pix_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // every fb write must match the next expected {bank, addr, data} in order
    always @(negedge pclk) begin
        if (rst_n) begin
            if (fb_we) begin
                if (exp_q.size() == 0) chk("fb_we_unexpected", 32'(fb_we), 0);
                else begin
                    exp_w = exp_q.pop_front();
                    chk("fb_write", 32'({fb_addr, fb_din}), 32'(exp_w));
                end
            end
            if (frame_done) begin
                fd_seen++;
                chk("frame_done_width", 32'(fd_prev), 0);
            end
            fd_prev = frame_done;
        end
    end

    task automatic chk_model(input string tag);
        chk({tag, ":front_bank"}, 32'(front_bank), 32'(m_front));
        chk({tag, ":frame_cnt"}, 32'(frame_cnt), 32'(m_frames % 256));
        chk({tag, ":drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
        chk({tag, ":frame_done_pulses"}, 32'(fd_seen), 32'(m_frames));
        chk({tag, ":writes_pending"}, 32'(exp_q.size()), 0);
        chk({tag, ":pix_err"}, 32'(pix_err), 32'(m_pix_err));
    endtask

    // one camera frame: vsync falls, npix writes at addresses 0..npix-1, vsync rises, blanking
    task automatic frame(input int npix, input bit cap, input bit bad, input bit rise_last,
                         input bit rel_busy);
        logic bank;
        bank  = ~m_front;
        vsync = 1'b0;
        tick();
        if (rel_busy) rd_busy = 1'b0;
        tick($urandom_range(0, 2));
        for (int i = 0; i < npix; i++) begin
            cap_addr = AW'(i);
            cap_dout = 16'($urandom);
            cap_we   = 1'b1;
            if (rise_last && i == npix - 1) vsync = 1'b1;
            if (cap) exp_q.push_back({bank, cap_addr, cap_dout});
            tick();
            cap_we = 1'b0;
            if (bad && i == 2) begin
                cap_addr = AW'(PIX);
                cap_dout = 16'($urandom);
                cap_we   = 1'b1;
                tick();
                cap_we   = 1'b0;
            end
            if (i != npix - 1) tick($urandom_range(0, 2));
        end
        if (!rise_last) begin
            tick($urandom_range(0, 2));
            vsync = 1'b1;
        end
        tick(4);
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; cont_mode = 1'b0; snap_req = 1'b0;
        vsync = 1'b1; rd_busy = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_dout = '0;
        tick(3);
        chk("rst:fb_we", 32'(fb_we), 0);
        chk("rst:fb_addr", 32'(fb_addr), 0);
        chk("rst:busy", 32'(busy), 0);
        chk_model("rst");
        rst_n = 1'b1;
        tick(2);

        // continuous capture: one warm-up frame skipped, then alternating banks
        cont_mode = 1'b1; enable = 1'b1;
        tick();
        chk("cont:busy", 32'(busy), 1);
        frame(PIX, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_model("skip");
        for (int f = 0; f < 4; f++) begin
            frame(PIX, 1'b1, rbit(), rbit(), 1'b0);
            m_front = ~m_front; m_frames++;
            chk_model("cont");
        end
        frame(PIX - 1, 1'b1, 1'b0, 1'b0, 1'b0);
        m_front = ~m_front; m_frames++; m_pix_err = PIXCHK;
        chk_model("short_frame");

        // reader blocks the swap: frame dropped, same bank rewritten, then swapped
        rd_busy = 1'b1;
        frame(PIX, 1'b1, rbit(), rbit(), 1'b0);
        chk_model("blocked");
        frame(PIX, 1'b1, rbit(), rbit(), 1'b1);
        m_drops++; m_front = ~m_front; m_frames++;
        chk_model("dropped");

        // enable removed after five writes
        vsync = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            cap_addr = AW'(i); cap_dout = 16'($urandom); cap_we = 1'b1;
            exp_q.push_back({~m_front, cap_addr, cap_dout});
            tick();
            cap_we = 1'b0;
        end
        cap_addr = AW'(5); cap_dout = 16'($urandom); cap_we = 1'b1; enable = 1'b0;
        tick();
        cap_we = 1'b0;
        chk("abort:fb_we", 32'(fb_we), 0);
        chk("abort:busy", 32'(busy), 0);
        for (int i = 6; i < PIX; i++) begin
            cap_addr = AW'(i); cap_we = 1'b1;
            tick();
            cap_we = 1'b0;
        end
        vsync = 1'b1;
        tick(4);
        chk_model("abort");

        // snapshot mode
        cont_mode = 1'b0; enable = 1'b1;
        tick(2);
        chk("snap:idle_wait", 32'(busy), 0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0; m_pix_err = 1'b0;
        chk("snap:busy", 32'(busy), 1);
        chk("snap:pix_err_clr", 32'(pix_err), 0);
        frame(PIX, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(PIX, 1'b1, rbit(), rbit(), 1'b0);
        m_front = ~m_front; m_frames++;
        chk_model("snap");
        chk("snap:done_idle", 32'(busy), 0);
        frame(PIX, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_model("snap_after");

        // snapshot waits for the reader and never drops
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        frame(PIX, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_busy = 1'b1;
        frame(PIX, 1'b1, rbit(), rbit(), 1'b0);
        frame(PIX, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_model("snap_hold");
        chk("snap_hold:busy", 32'(busy), 1);
        rd_busy = 1'b0;
        tick(3);
        m_front = ~m_front; m_frames++;
        chk_model("snap_release");
        chk("snap_release:busy", 32'(busy), 0);

        // enable raised mid-frame: that frame and its remainder are never captured
        enable = 1'b0; cont_mode = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                enable = 1'b1;
                tick();
                chk("mid_en:busy", 32'(busy), 1);
            end
            cap_addr = AW'(i); cap_dout = 16'($urandom); cap_we = 1'b1;
            tick();
            cap_we = 1'b0;
        end
        vsync = 1'b1;
        tick(4);
        chk_model("mid_en");
        frame(PIX, 1'b1, rbit(), rbit(), 1'b0);
        m_front = ~m_front; m_frames++;
        chk_model("mid_en_capture");

        enable = 1'b0;
        tick(2);
        chk("end:busy", 32'(busy), 0);
        chk("end:fb_we", 32'(fb_we), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
